// File: rtl/avalon_mm_arbiter.sv
// Two-port round-robin Avalon-MM arbiter with one shared master port.
// Ports: s0_*/s1_* requester slaves, m_* shared master, grant, stray_rdv.
module avalon_mm_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  output logic                s0_response,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_response,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [1:0]          grant,
  output logic                stray_rdv
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [BE_W-1:0]     cmd_be;
  logic                cmd_wr;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          rdv_q;
  logic [1:0]          resp_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                stray_q;

  logic req0, req1, pick1;
  logic load, sel1;
  logic rd_done, to_done, done;
  logic accept;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;

  // s1 wins when alone, or on a tie when s0 was served last.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    load    = 1'b0;
    sel1    = 1'b0;
    rd_done = 1'b0;
    to_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          load    = 1'b1;
          sel1    = pick1;
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          if (cmd_wr) begin
            state_d = IDLE;
            grant_d = 2'b00;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (m_readdatavalid) begin
          rd_done = 1'b1;
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          to_done = 1'b1;
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign done = rd_done | to_done;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
      cmd_wr    <= 1'b0;
      cnt_q     <= '0;
      rdv_q     <= 2'b00;
      resp_q    <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      stray_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      if (load) begin
        cmd_addr  <= sel1 ? s1_address : s0_address;
        cmd_wdata <= sel1 ? s1_writedata : s0_writedata;
        cmd_be    <= sel1 ? s1_byteenable : s0_byteenable;
        // write has priority when both strobes are up
        cmd_wr    <= sel1 ? s1_write : s0_write;
      end
      cnt_q  <= (state_q == WAIT_RD) ? cnt_q + 1'b1 : '0;
      rdv_q  <= done ? grant_q : 2'b00;
      resp_q <= to_done ? grant_q : 2'b00;
      if (done && grant_q[0])
        rdata0_q <= to_done ? '0 : m_readdata;
      if (done && grant_q[1])
        rdata1_q <= to_done ? '0 : m_readdata;
      if (m_readdatavalid && state_q != WAIT_RD)
        stray_q <= 1'b1;
    end
  end

  assign accept = (state_q == ISSUE) & ~m_waitrequest;

  assign m_address    = cmd_addr;
  assign m_writedata  = cmd_wdata;
  assign m_byteenable = cmd_be;
  assign m_read       = (state_q == ISSUE) & ~cmd_wr;
  assign m_write      = (state_q == ISSUE) & cmd_wr;

  assign s0_waitrequest   = ~(accept & grant_q[0]);
  assign s1_waitrequest   = ~(accept & grant_q[1]);
  assign s0_readdata      = rdata0_q;
  assign s1_readdata      = rdata1_q;
  assign s0_readdatavalid = rdv_q[0];
  assign s1_readdatavalid = rdv_q[1];
  assign s0_response      = resp_q[0];
  assign s1_response      = resp_q[1];

  assign grant     = grant_q;
  assign stray_rdv = stray_q;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench for avalon_mm_arbiter: vector table plus
// hand sequences for read return, watchdog and mid-op reset.
module tb_avalon_mm_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] s0_address, s1_address;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_writedata, s1_writedata;
  logic [3:0]  s0_byteenable, s1_byteenable;
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic        s0_response, s1_response;
  logic [31:0] m_address, m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_read, m_write;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [1:0]  grant;
  logic        stray_rdv;

  always #5 clk_clk = ~clk_clk;

  avalon_mm_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .s0_address(s0_address), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata),
    .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s0_response(s0_response),
    .s1_address(s1_address), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .s1_response(s1_response),
    .m_address(m_address), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_read(m_read),
    .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .grant(grant), .stray_rdv(stray_rdv)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic        s0r, s0w;
    logic [31:0] s0a, s0d;
    logic        s1r, s1w;
    logic [31:0] s1a, s1d;
    logic        mw;
    logic        emr, emw;
    logic [31:0] ema, emd;
    logic [3:0]  ebe;
    logic [1:0]  eg;
    logic        e0w, e1w;
  } vec_t;

  function automatic vec_t mk(
    input logic s0r, input logic s0w,
    input logic [31:0] s0a, input logic [31:0] s0d,
    input logic s1r, input logic s1w,
    input logic [31:0] s1a, input logic [31:0] s1d,
    input logic mw, input logic emr, input logic emw,
    input logic [31:0] ema, input logic [31:0] emd,
    input logic [3:0] ebe, input logic [1:0] eg,
    input logic e0w, input logic e1w);
    vec_t v;
    v.s0r = s0r; v.s0w = s0w; v.s0a = s0a; v.s0d = s0d;
    v.s1r = s1r; v.s1w = s1w; v.s1a = s1a; v.s1d = s1d;
    v.mw = mw; v.emr = emr; v.emw = emw;
    v.ema = ema; v.emd = emd; v.ebe = ebe;
    v.eg = eg; v.e0w = e0w; v.e1w = e1w;
    return v;
  endfunction

  vec_t tbl[16];

  logic mon_en = 1'b0;
  logic s0_rdv_seen = 1'b0;
  always @(negedge clk_clk)
    if (mon_en && s0_readdatavalid) s0_rdv_seen = 1'b1;

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    reset_reset_n   = 1'b0;
    s0_address      = '0; s1_address = '0;
    s0_read         = 0; s0_write = 0;
    s1_read         = 0; s1_write = 0;
    s0_writedata    = '0; s1_writedata = '0;
    s0_byteenable   = 4'hF; s1_byteenable = 4'h3;
    m_waitrequest   = 0; m_readdata = '0;
    m_readdatavalid = 0;

    // both writing continuously, then rd+wr, then stalled write
    tbl[0]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,0,0,0,0,2'b00,1,1);
    tbl[1]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,1,'hA0,'hD0,4'hF,2'b01,0,1);
    tbl[2]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,0,0,0,0,2'b00,1,1);
    tbl[3]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,1,'hB0,'hD1,4'h3,2'b10,1,0);
    tbl[4]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,0,0,0,0,2'b00,1,1);
    tbl[5]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,1,'hA0,'hD0,4'hF,2'b01,0,1);
    tbl[6]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,0,0,0,0,2'b00,1,1);
    tbl[7]  = mk(0,1,'hA0,'hD0, 0,1,'hB0,'hD1, 0, 0,1,'hB0,'hD1,4'h3,2'b10,1,0);
    tbl[8]  = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,2'b00,1,1);
    tbl[9]  = mk(1,1,'h20,'h55, 0,0,0,0, 0, 0,0,0,0,0,2'b00,1,1);
    tbl[10] = mk(1,1,'h20,'h55, 0,0,0,0, 0, 0,1,'h20,'h55,4'hF,2'b01,0,1);
    tbl[11] = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,2'b00,1,1);
    tbl[12] = mk(0,0,0,0, 0,1,'h30,'h77, 1, 0,0,0,0,0,2'b00,1,1);
    tbl[13] = mk(0,0,0,0, 0,1,'h30,'h77, 1, 0,1,'h30,'h77,4'h3,2'b10,1,1);
    tbl[14] = mk(0,0,0,0, 0,1,'h30,'h77, 0, 0,1,'h30,'h77,4'h3,2'b10,1,0);
    tbl[15] = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,2'b00,1,1);

    // reset state
    repeat (2) @(posedge clk_clk);
    #1;
    @(negedge clk_clk);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_addr", m_address, 0);
    chk("rst_grant", grant, 0);
    chk("rst_s0_wait", s0_waitrequest, 1);
    chk("rst_s1_wait", s1_waitrequest, 1);
    chk("rst_s0_rdv", s0_readdatavalid, 0);
    chk("rst_s1_rdv", s1_readdatavalid, 0);
    chk("rst_stray", stray_rdv, 0);
    chk("rst_s0_rdata", s0_readdata, 0);
    step();
    reset_reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      s0_read = tbl[i].s0r; s0_write = tbl[i].s0w;
      s0_address = tbl[i].s0a; s0_writedata = tbl[i].s0d;
      s1_read = tbl[i].s1r; s1_write = tbl[i].s1w;
      s1_address = tbl[i].s1a; s1_writedata = tbl[i].s1d;
      m_waitrequest = tbl[i].mw;
      @(negedge clk_clk);
      chk($sformatf("v%0d_m_read", i), m_read, tbl[i].emr);
      chk($sformatf("v%0d_m_write", i), m_write, tbl[i].emw);
      chk($sformatf("v%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("v%0d_s0_wait", i), s0_waitrequest, tbl[i].e0w);
      chk($sformatf("v%0d_s1_wait", i), s1_waitrequest, tbl[i].e1w);
      if (tbl[i].emr || tbl[i].emw) begin
        chk($sformatf("v%0d_m_addr", i), m_address, tbl[i].ema);
        chk($sformatf("v%0d_m_wdata", i), m_writedata, tbl[i].emd);
        chk($sformatf("v%0d_m_be", i), m_byteenable, tbl[i].ebe);
      end
      step();
    end

    // s1 read with 3 stall cycles, data 5 cycles after accept
    mon_en = 1'b1;
    s1_read = 1; s1_address = 32'h100; m_waitrequest = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      chk("rd_stall_m_read", m_read, 1);
      chk("rd_stall_s1_wait", s1_waitrequest, 1);
      step();
    end
    m_waitrequest = 0;
    @(negedge clk_clk);
    chk("rd_acc_m_read", m_read, 1);
    chk("rd_acc_m_addr", m_address, 32'h100);
    chk("rd_acc_s1_wait", s1_waitrequest, 0);
    step();
    s1_read = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_clk);
      chk("rd_wait_m_read", m_read, 0);
      chk("rd_wait_s1_rdv", s1_readdatavalid, 0);
      step();
    end
    m_readdatavalid = 1; m_readdata = 32'hCAFEF00D;
    step();
    m_readdatavalid = 0; m_readdata = '0;
    @(negedge clk_clk);
    chk("rd_s1_rdv", s1_readdatavalid, 1);
    chk("rd_s1_data", s1_readdata, 32'hCAFEF00D);
    chk("rd_s1_resp", s1_response, 0);
    chk("rd_grant", grant, 0);
    step();
    @(negedge clk_clk);
    chk("rd_s1_rdv_pulse", s1_readdatavalid, 0);
    chk("rd_s1_data_hold", s1_readdata, 32'hCAFEF00D);
    step();
    mon_en = 1'b0;
    chk("rd_s0_rdv_never", s0_rdv_seen, 0);

    // s0 read never answered: watchdog then stray data
    s0_read = 1; s0_address = 32'h200;
    step();
    @(negedge clk_clk);
    chk("to_m_read", m_read, 1);
    chk("to_s0_wait", s0_waitrequest, 0);
    step();
    s0_read = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_clk);
      chk($sformatf("to_early_rdv_%0d", k), s0_readdatavalid, 0);
      step();
    end
    @(negedge clk_clk);
    chk("to_s0_rdv", s0_readdatavalid, 1);
    chk("to_s0_resp", s0_response, 1);
    chk("to_s0_data", s0_readdata, 0);
    chk("to_grant", grant, 0);
    chk("to_stray_pre", stray_rdv, 0);
    step();
    m_readdatavalid = 1; m_readdata = 32'hDEAD;
    @(negedge clk_clk);
    chk("to_rdv_pulse", s0_readdatavalid, 0);
    step();
    m_readdatavalid = 0; m_readdata = '0;
    @(negedge clk_clk);
    chk("stray_set", stray_rdv, 1);
    chk("stray_no_rdv", s0_readdatavalid, 0);
    step();

    // reset while s0 read is stalled in ISSUE
    s0_read = 1; s0_address = 32'h300; m_waitrequest = 1;
    step();
    @(negedge clk_clk);
    chk("mr_m_read", m_read, 1);
    reset_reset_n = 0;
    step();
    reset_reset_n = 1;
    s0_read = 0; m_waitrequest = 0;
    s0_write = 1; s0_address = 32'h400;
    s1_write = 1; s1_address = 32'h500;
    @(negedge clk_clk);
    chk("mr_m_read0", m_read, 0);
    chk("mr_m_write0", m_write, 0);
    chk("mr_grant", grant, 0);
    chk("mr_s0_wait", s0_waitrequest, 1);
    chk("mr_s1_wait", s1_waitrequest, 1);
    chk("mr_stray_clr", stray_rdv, 0);
    step();
    @(negedge clk_clk);
    chk("mr_tie_grant", grant, 2'b01);
    chk("mr_tie_addr", m_address, 32'h400);
    chk("mr_tie_write", m_write, 1);
    step();
    s0_write = 0; s1_write = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
